// File: rtl/amstrad_crtc_if.sv
// CPU-side register port of the CRTC: chip select, register select,
// read/write strobes and the two data buses.
interface amstrad_crtc_if;
    logic       CS;
    logic       RS;
    logic       WE;
    logic       RD;
    logic [7:0] D;
    logic [7:0] Q;

    modport master (output CS, output RS, output WE, output RD, output D, input Q);
    modport slave  (input CS, input RS, input WE, input RD, input D, output Q);
endinterface

// File: rtl/amstrad_crtc.sv
// UM6845R (type 1) CRTC: character/scanline/row counters, HSYNC/VSYNC/DE
// generation and MA/RA video addressing, advanced on the character enable.
module amstrad_crtc #(
    parameter int VS_LINES = 16
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          CE,
    amstrad_crtc_if.slave bus,
    output logic          HSYNC,
    output logic          VSYNC,
    output logic          DE,
    output logic [13:0]   MA,
    output logic [4:0]    RA
);
    localparam int VSW = $clog2(VS_LINES + 1);

    typedef enum logic [0:0] {
        V_DISPLAY = 1'b0,
        V_ADJUST  = 1'b1
    } vstate_t;

    // Implemented bits of each register; unimplemented addresses store nothing.
    function automatic logic [7:0] reg_mask(input logic [4:0] addr);
        case (addr)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd13, 5'd15: reg_mask = 8'hFF;
            5'd4, 5'd6, 5'd7, 5'd10:              reg_mask = 8'h7F;
            5'd5, 5'd9, 5'd11:                    reg_mask = 8'h1F;
            5'd8:                                 reg_mask = 8'h03;
            5'd12, 5'd14:                         reg_mask = 8'h3F;
            default:                              reg_mask = 8'h00;
        endcase
    endfunction

    logic [7:0]     regs_r [16];
    logic [4:0]     addr_r;
    logic [7:0]     q_r;
    logic [7:0]     rd_data_s;

    logic [7:0]     hcc_r;
    logic [4:0]     vlc_r;
    logic [6:0]     vcc_r;
    logic [13:0]    ma_row_r;
    logic [13:0]    ma_next_r;
    logic           first_r;
    vstate_t        vstate_r;
    vstate_t        vstate_s;

    logic           line_end_s;
    logic           row_end_s;
    logic           frame_end_s;
    logic           adj_end_s;
    logic           new_frame_s;
    logic [13:0]    ma_start_s;
    logic [13:0]    ma_base_s;
    logic [13:0]    ma_next_s;

    logic [3:0]     hs_width_s;
    logic [3:0]     hs_left_r;
    logic [VSW-1:0] vs_lines_r;
    logic           hsync_r;
    logic           vsync_r;
    logic           de_r;
    logic [13:0]    ma_r;
    logic [4:0]     ra_r;

    assign HSYNC = hsync_r;
    assign VSYNC = vsync_r;
    assign DE    = de_r;
    assign MA    = ma_r;
    assign RA    = ra_r;
    assign bus.Q = q_r;

    // Address register and masked register file written from the CPU port
    always_ff @(posedge CLK) begin
        if (RESET) begin
            addr_r <= 5'd0;
            for (int i = 0; i < 16; i++) begin
                regs_r[i] <= 8'h00;
            end
        end else if (bus.CS && bus.WE) begin
            if (!bus.RS) begin
                addr_r <= bus.D[4:0];
            end else if (!addr_r[4]) begin
                regs_r[addr_r[3:0]] <= bus.D & reg_mask(addr_r);
            end
        end
    end

    // Read mux: status byte or R12..R17 (light pen R16/R17 always read zero)
    always_comb begin
        rd_data_s = 8'h00;
        if (!bus.RS) begin
            rd_data_s = {2'b00, vsync_r, 5'b00000};
        end else begin
            case (addr_r)
                5'd12, 5'd13, 5'd14, 5'd15: rd_data_s = regs_r[addr_r[3:0]];
                default:                    rd_data_s = 8'h00;
            endcase
        end
    end

    // Registered CPU read data, updated on each qualified read strobe
    always_ff @(posedge CLK) begin
        if (RESET) begin
            q_r <= 8'h00;
        end else if (bus.CS && bus.RD) begin
            q_r <= rd_data_s;
        end
    end

    // Counter compares and row address selection
    always_comb begin
        hs_width_s  = regs_r[3][3:0];
        line_end_s  = (hcc_r == regs_r[0]);
        row_end_s   = (vlc_r == regs_r[9][4:0]);
        frame_end_s = row_end_s && (vcc_r == regs_r[4][6:0]);
        adj_end_s   = (vlc_r == (regs_r[5][4:0] - 5'd1));
        ma_start_s  = {regs_r[12][5:0], regs_r[13]};
        // The first character after reset is a frame start, so it uses R12/R13.
        if (first_r) begin
            ma_base_s = ma_start_s;
        end else begin
            ma_base_s = ma_row_r;
        end
        if ((hcc_r == regs_r[1]) && row_end_s) begin
            ma_next_s = ma_base_s + {6'd0, regs_r[1]};
        end else begin
            ma_next_s = ma_next_r;
        end
    end

    // Vertical FSM next state: display rows versus vertical-adjust scanlines
    always_comb begin
        vstate_s    = vstate_r;
        new_frame_s = 1'b0;
        if (CE && line_end_s) begin
            case (vstate_r)
                V_DISPLAY: begin
                    if (frame_end_s && (regs_r[5][4:0] != 5'd0)) begin
                        vstate_s = V_ADJUST;
                    end else begin
                        vstate_s    = V_DISPLAY;
                        new_frame_s = frame_end_s;
                    end
                end
                V_ADJUST: begin
                    if (adj_end_s) begin
                        vstate_s    = V_DISPLAY;
                        new_frame_s = 1'b1;
                    end else begin
                        vstate_s = V_ADJUST;
                    end
                end
                default: vstate_s = V_DISPLAY;
            endcase
        end else begin
            vstate_s = vstate_r;
        end
    end

    // Vertical FSM state register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            vstate_r <= V_DISPLAY;
        end else begin
            vstate_r <= vstate_s;
        end
    end

    // Character, scanline and row counters plus the row start address
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hcc_r     <= 8'd0;
            vlc_r     <= 5'd0;
            vcc_r     <= 7'd0;
            ma_row_r  <= 14'd0;
            ma_next_r <= 14'd0;
            first_r   <= 1'b1;
        end else if (CE) begin
            first_r   <= 1'b0;
            ma_next_r <= ma_next_s;
            ma_row_r  <= ma_base_s;
            if (line_end_s) begin
                hcc_r <= 8'd0;
                if (new_frame_s) begin
                    vlc_r    <= 5'd0;
                    vcc_r    <= 7'd0;
                    ma_row_r <= ma_start_s;
                end else if ((vstate_r == V_DISPLAY) && row_end_s) begin
                    // Row end; on the last row this is the entry into adjust.
                    vlc_r    <= 5'd0;
                    ma_row_r <= ma_next_s;
                    if (!frame_end_s) begin
                        vcc_r <= vcc_r + 7'd1;
                    end
                end else begin
                    vlc_r <= vlc_r + 5'd1;
                end
            end else begin
                hcc_r <= hcc_r + 8'd1;
            end
        end
    end

    // Registered video outputs derived from the counters seen at this CE
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hsync_r    <= 1'b0;
            vsync_r    <= 1'b0;
            de_r       <= 1'b0;
            ma_r       <= 14'd0;
            ra_r       <= 5'd0;
            hs_left_r  <= 4'd0;
            vs_lines_r <= '0;
        end else if (CE) begin
            de_r <= (hcc_r < regs_r[1]) && (vcc_r < regs_r[6][6:0]) && (vstate_r == V_DISPLAY);
            ma_r <= ma_base_s + {6'd0, hcc_r};
            ra_r <= vlc_r;

            // HSYNC width runs on its own down-counter, so it spans line ends.
            if ((hcc_r == regs_r[2]) && (hs_width_s != 4'd0)) begin
                hsync_r   <= 1'b1;
                hs_left_r <= hs_width_s - 4'd1;
            end else if (hs_left_r != 4'd0) begin
                hsync_r   <= 1'b1;
                hs_left_r <= hs_left_r - 4'd1;
            end else begin
                hsync_r <= 1'b0;
            end

            // VSYNC ends at the line start after VS_LINES line ends; a frame
            // restart does not touch it and a retrigger while high is ignored.
            if (vsync_r && (hcc_r == 8'd0) && (vs_lines_r == VSW'(VS_LINES))) begin
                vsync_r <= 1'b0;
            end else if (!vsync_r && (hcc_r == 8'd0) && (vlc_r == 5'd0) &&
                         (vcc_r == regs_r[7][6:0]) && (vstate_r == V_DISPLAY)) begin
                vsync_r    <= 1'b1;
                vs_lines_r <= '0;
            end else if (vsync_r && line_end_s) begin
                vs_lines_r <= vs_lines_r + VSW'(1);
            end
        end
    end
endmodule

// File: tb/tb_amstrad_crtc.sv
// Randomized self-checking bench for amstrad_crtc against a frame-position
// reference model (line/row/column arithmetic per character).
module tb_amstrad_crtc;
    localparam int VS = 16;

    logic        CLK;
    logic        RESET;
    logic        CE;
    logic        HSYNC;
    logic        VSYNC;
    logic        DE;
    logic [13:0] MA;
    logic [4:0]  RA;

    amstrad_crtc_if bus ();

    amstrad_crtc #(.VS_LINES(VS)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .CE    (CE),
        .bus   (bus),
        .HSYNC (HSYNC),
        .VSYNC (VSYNC),
        .DE    (DE),
        .MA    (MA),
        .RA    (RA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          n_vec;
    int          n_err;
    logic [7:0]  raw [16];
    int          cfg [16];
    int          start_addr;
    int          pos;
    bit          vs_on;
    int          vs_g;
    // per-run measurements
    int          hs_rise0, hs_rise1, hs_fall0, vs_rise0, vs_fall0, fs0, fs1;
    int          hs_cnt, de_cnt, de_frame, ra_max;
    logic [14:0] first_dm, row1_dm;
    logic        prev_hs, prev_vs;
    logic [7:0]  q;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int spec_mask(input int a);
        case (a)
            0, 1, 2, 3, 13, 15: return 'hFF;
            4, 6, 7, 10:        return 'h7F;
            5, 9, 11:           return 'h1F;
            8:                  return 'h03;
            12, 14:             return 'h3F;
            default:            return 0;
        endcase
    endfunction

    task automatic cpu_write(input logic rs, input logic [7:0] d);
        @(negedge CLK);
        bus.CS = 1'b1; bus.RS = rs; bus.WE = 1'b1; bus.D = d;
        @(negedge CLK);
        bus.CS = 1'b0; bus.WE = 1'b0;
    endtask

    task automatic cpu_read(input logic rs, output logic [7:0] d);
        @(negedge CLK);
        bus.CS = 1'b1; bus.RS = rs; bus.RD = 1'b1;
        @(negedge CLK);
        bus.CS = 1'b0; bus.RD = 1'b0;
        d = bus.Q;
    endtask

    task automatic do_reset(input logic ce_val);
        @(negedge CLK);
        RESET = 1'b1; CE = ce_val;
        @(posedge CLK);
        #1;
        RESET = 1'b0; CE = 1'b0;
        check_val("reset_outputs", 32'({HSYNC, VSYNC, DE, MA, RA}), 32'd0);
        check_val("reset_q", 32'(bus.Q), 32'd0);
    endtask

    task automatic load_default();
        for (int i = 0; i < 16; i++) raw[i] = 8'h00;
        raw[0] = 8'd63; raw[1] = 8'd40; raw[2] = 8'd46; raw[3] = 8'h8E;
        raw[4] = 8'd38; raw[6] = 8'd25; raw[7] = 8'd30; raw[9] = 8'd7;
        raw[12] = 8'h30; raw[13] = 8'h00;
    endtask

    task automatic program_regs();
        for (int i = 0; i < 16; i++) begin
            cpu_write(1'b0, 8'(i));
            cpu_write(1'b1, raw[i]);
            cfg[i] = int'(raw[i]) & spec_mask(i);
        end
        start_addr = ((cfg[12] & 'h3F) << 8) | cfg[13];
        pos = 0; vs_on = 1'b0; vs_g = 0;
        hs_rise0 = -1; hs_rise1 = -1; hs_fall0 = -1; vs_rise0 = -1; vs_fall0 = -1;
        fs0 = -1; fs1 = -1; hs_cnt = 0; de_cnt = 0; de_frame = 0; ra_max = 0;
        first_dm = '0; row1_dm = '0; prev_hs = 1'b0; prev_vs = 1'b0;
    endtask

    // Expected outputs for the character at position pos since the frame restart.
    task automatic model_step(output logic [21:0] e);
        int  len, nl, lpf, p, fl, col, g, vlc, vcc, base, w, j;
        bit  adj, hs, de;
        len = cfg[0] + 1;
        nl  = (cfg[4] + 1) * (cfg[9] + 1);
        lpf = nl + cfg[5];
        p   = pos % (len * lpf);
        fl  = p / len;
        col = p % len;
        g   = pos / len;
        adj = (fl >= nl);
        if (adj) begin
            vlc  = fl - nl;
            vcc  = cfg[4];
            base = start_addr + (cfg[4] + 1) * cfg[1];
        end else begin
            vcc  = fl / (cfg[9] + 1);
            vlc  = fl % (cfg[9] + 1);
            base = start_addr + vcc * cfg[1];
        end
        if (col == 0) begin
            if (vs_on && (g - vs_g == VS)) vs_on = 1'b0;
            else if (!vs_on && !adj && vlc == 0 && vcc == cfg[7]) begin
                vs_on = 1'b1;
                vs_g  = g;
            end
        end
        w  = cfg[3] & 15;
        hs = 1'b0;
        if (w != 0 && cfg[2] < len) begin
            j  = (col - cfg[2] + len) % len;
            hs = (j < w) && (pos >= j);
        end
        de = (col < cfg[1]) && (vcc < cfg[6]) && !adj;
        e  = {hs, vs_on, de, 14'((base + col) & 'h3FFF), 5'(vlc)};
    endtask

    task automatic run_ce(input int count);
        logic [21:0] e;
        logic [21:0] got;
        int          row1_pos;
        row1_pos = (cfg[0] + 1) * (cfg[9] + 1);
        for (int k = 0; k < count; k++) begin
            @(negedge CLK);
            CE = 1'b1;
            @(posedge CLK);
            #1;
            CE = 1'b0;
            model_step(e);
            got = {HSYNC, VSYNC, DE, MA, RA};
            check_val($sformatf("vec@%0d", pos), 32'(got), 32'(e));
            if (HSYNC && !prev_hs) begin
                if (hs_rise0 < 0) hs_rise0 = pos;
                else if (hs_rise1 < 0) hs_rise1 = pos;
            end
            if (!HSYNC && prev_hs && hs_fall0 < 0) hs_fall0 = pos;
            if (VSYNC && !prev_vs && vs_rise0 < 0) vs_rise0 = pos;
            if (!VSYNC && prev_vs && vs_fall0 < 0) vs_fall0 = pos;
            if (DE && int'(MA) == start_addr && RA == 5'd0) begin
                if (fs0 < 0) fs0 = pos;
                else if (fs1 < 0) fs1 = pos;
            end
            if (fs1 < 0 && DE) de_frame++;
            if (pos == 0) first_dm = {DE, MA};
            if (pos == row1_pos) row1_dm = {DE, MA};
            if (int'(RA) > ra_max) ra_max = int'(RA);
            if (HSYNC) hs_cnt++;
            if (DE) de_cnt++;
            prev_hs = HSYNC;
            prev_vs = VSYNC;
            pos++;
        end
    endtask

    initial begin
        int len, lpf;
        n_vec = 0; n_err = 0;
        CE = 1'b0; RESET = 1'b0;
        bus.CS = 1'b0; bus.RS = 1'b0; bus.WE = 1'b0; bus.RD = 1'b0; bus.D = 8'h00;
        repeat (2) @(posedge CLK);
        do_reset(1'b0);

        // Register access and masking
        cpu_write(1'b0, 8'd12); cpu_write(1'b1, 8'hFF); cpu_read(1'b1, q);
        check_val("r12_readback", 32'(q), 32'h3F);
        cpu_write(1'b0, 8'd3); cpu_write(1'b1, 8'h8E); cpu_read(1'b1, q);
        check_val("r3_read_zero", 32'(q), 32'h00);
        cpu_write(1'b0, 8'd16); cpu_write(1'b1, 8'h5A); cpu_read(1'b1, q);
        check_val("r16_ignored", 32'(q), 32'h00);
        cpu_read(1'b0, q);
        check_val("status_idle", 32'(q), 32'h00);

        // CPC default setup
        load_default();
        program_regs();
        run_ce(15500);
        cpu_read(1'b0, q);
        check_val("status_in_vsync", 32'(q), 32'h20);
        run_ce(30220 - 15500);
        check_val("hs_start_col", 32'(hs_rise0), 32'd46);
        check_val("hs_width", 32'(hs_fall0 - hs_rise0), 32'd14);
        check_val("line_len", 32'(hs_rise1 - hs_rise0), 32'd64);
        check_val("vs_len", 32'(vs_fall0 - vs_rise0), 32'd1024);
        check_val("frame_len", 32'(fs1 - fs0), 32'd19968);
        check_val("first_de_ma", 32'(first_dm), 32'h7000);
        check_val("row1_ma", 32'(row1_dm), 32'h7028);
        check_val("ra_max", 32'(ra_max), 32'd7);
        check_val("de_per_frame", 32'(de_frame), 32'd8000);

        // Reset mid-frame (vcc = 20) clears registers too
        do_reset(1'b1);
        cpu_write(1'b0, 8'd12); cpu_read(1'b1, q);
        check_val("r12_after_reset", 32'(q), 32'h00);

        // Vertical adjust of two lines
        load_default();
        raw[5] = 8'd2;
        program_regs();
        run_ce(20200);
        check_val("hs_after_reset", 32'(hs_rise0), 32'd46);
        check_val("frame_len_adj", 32'(fs1 - fs0), 32'd20096);
        check_val("de_per_frame_adj", 32'(de_frame), 32'd8000);

        // Randomized small configurations
        for (int c = 0; c < 4; c++) begin
            do_reset(1'b0);
            for (int i = 0; i < 16; i++) raw[i] = 8'($urandom);
            raw[0] = 8'($urandom_range(15, 40));
            raw[1] = 8'($urandom_range(0, int'(raw[0])));
            raw[2] = 8'($urandom_range(0, int'(raw[0])));
            raw[4] = 8'($urandom_range(2, 7) | ($urandom_range(0, 1) << 7));
            raw[5] = 8'($urandom_range(0, 3) | ($urandom_range(0, 7) << 5));
            raw[6] = 8'($urandom_range(0, 9));
            raw[7] = 8'($urandom_range(0, 8));
            raw[9] = 8'($urandom_range(1, 5) | ($urandom_range(0, 7) << 5));
            if (c == 0) raw[3] = raw[3] & 8'hF0;
            if (c == 1) raw[6] = 8'h00;
            program_regs();
            len = cfg[0] + 1;
            lpf = (cfg[4] + 1) * (cfg[9] + 1) + cfg[5];
            run_ce(2 * len * lpf + 3 * len);
            if (c == 0) check_val("hs_never_w0", 32'(hs_cnt), 32'd0);
            if (c == 1) check_val("de_never_r6_0", 32'(de_cnt), 32'd0);
            for (int a = 0; a < 18; a++) begin
                cpu_write(1'b0, 8'(a));
                cpu_read(1'b1, q);
                check_val($sformatf("rd_r%0d_cfg%0d", a, c), 32'(q),
                          (a >= 12 && a <= 15) ? 32'(cfg[a]) : 32'd0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
